mac_sequencer: RTL and testbench



---
 rtl/mac_sequencer.sv | 153 +++++++++++++++
 tb/tb_mac_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer
// Sequences an external combinational multiply-accumulate datapath over a
// vector of weight/value pairs. A job (length, number format, initial
// accumulator) is latched on start; pairs stream in over in_valid/in_ready.
// The registered running sum is fed back to the datapath as its cumulative
// operand. Sticky overflow is collected across the job, and the final sum is
// offered on a valid/ready result port.
//
// Ports
//   clk, n_rst                    clock, async active-low reset
//   start, len, float_mode,       job request and job fields
//   init_acc                      (len 0 encodes 16)
//   abort                         synchronous cancel, highest priority
//   in_valid, in_weight,          operand pair stream
//   in_value, in_ready
//   mul_weight, mul_value,        operands to the datapath
//   mul_cumulative, mul_float
//   mul_out, mul_overflow         datapath result and saturation flag
//   busy                          job in progress or result pending
//   res_valid, res_ready,         result handshake
//   result, res_overflow,
//   res_count
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; no pairs taken, no result offered
// RUN   | accepting pairs; acc tracks datapath output
// DONE  | final sum held on result port until res_ready
module mac_sequencer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [3:0] len,
    input  logic       float_mode,
    input  logic [7:0] init_acc,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_weight,
    input  logic [7:0] in_value,
    output logic       in_ready,
    output logic [7:0] mul_weight,
    output logic [7:0] mul_value,
    output logic [7:0] mul_cumulative,
    output logic       mul_float,
    input  logic [7:0] mul_out,
    input  logic       mul_overflow,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] result,
    output logic       res_overflow,
    output logic [4:0] res_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] len_q;
    logic [4:0] cnt;
    logic       float_q;
    logic       ovf;
    logic [7:0] acc;
    logic       accept;
    logic       last_pair;

    // in_ready is a pure state decode, so accept has no comb loop back
    // through the upstream valid logic.
    assign accept    = in_valid && (state == ST_RUN);
    assign last_pair = accept && ((cnt + 5'd1) == len_q);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_pair) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len_q   <= 5'd0;
            float_q <= 1'b0;
            acc     <= 8'h00;
            cnt     <= 5'd0;
            ovf     <= 1'b0;
        end else if (abort) begin
            // The pair offered alongside abort is dropped; float_q is kept so
            // mul_float still reflects the last latched job.
            acc <= 8'h00;
            cnt <= 5'd0;
            ovf <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= (len == 4'd0) ? 5'd16 : {1'b0, len};
                        float_q <= float_mode;
                        acc     <= init_acc;
                        cnt     <= 5'd0;
                        ovf     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        acc <= mul_out;
                        ovf <= ovf | mul_overflow;
                        if (cnt != 5'd16) cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_weight     = in_weight;
    assign mul_value      = in_value;
    assign mul_cumulative = acc;
    assign mul_float      = float_q;

    assign result       = acc;
    assign res_overflow = ovf;
    assign res_count    = cnt;

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic [3:0] len;
    logic       float_mode;
    logic [7:0] init_acc;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_weight;
    logic [7:0] in_value;
    logic       in_ready;
    logic [7:0] mul_weight;
    logic [7:0] mul_value;
    logic [7:0] mul_cumulative;
    logic       mul_float;
    logic [7:0] mul_out;
    logic       mul_overflow;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic       res_overflow;
    logic [4:0] res_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_sequencer dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .len            (len),
        .float_mode     (float_mode),
        .init_acc       (init_acc),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_weight      (in_weight),
        .in_value       (in_value),
        .in_ready       (in_ready),
        .mul_weight     (mul_weight),
        .mul_value      (mul_value),
        .mul_cumulative (mul_cumulative),
        .mul_float      (mul_float),
        .mul_out        (mul_out),
        .mul_overflow   (mul_overflow),
        .busy           (busy),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .result         (result),
        .res_overflow   (res_overflow),
        .res_count      (res_count)
    );

    // Environment datapath: int8 mode is a saturating signed w*v+c; float8
    // mode is a stand-in mapping ((w^v)+c, never overflows) so the bench can
    // see that every accumulator update follows mul_out.
    function automatic logic [8:0] dp(input logic [7:0] w, input logic [7:0] v,
                                      input logic [7:0] c, input logic f);
        int         s;
        logic [7:0] t;
        if (f) begin
            t = (w ^ v) + c;
            return {1'b0, t};
        end
        s = int'($signed(w)) * int'($signed(v)) + int'($signed(c));
        if (s > 127)  return {1'b1, 8'h7F};
        if (s < -128) return {1'b1, 8'h80};
        return {1'b0, s[7:0]};
    endfunction

    assign {mul_overflow, mul_out} = dp(mul_weight, mul_value, mul_cumulative, mul_float);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Job-level reference: a job has pairs left to take, or a result waiting.
    logic       m_running;
    logic       m_done;
    int         m_left;
    logic [7:0] m_acc;
    int         m_cnt;
    logic       m_ovf;
    logic       m_float;
    logic [8:0] m_dp;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_running = 1'b0;
            m_done    = 1'b0;
            m_left    = 0;
            m_acc     = 8'h00;
            m_cnt     = 0;
            m_ovf     = 1'b0;
            m_float   = 1'b0;
        end else if (abort) begin
            m_running = 1'b0;
            m_done    = 1'b0;
            m_acc     = 8'h00;
            m_cnt     = 0;
            m_ovf     = 1'b0;
        end else if (m_running) begin
            if (in_valid) begin
                m_dp   = dp(in_weight, in_value, m_acc, m_float);
                m_acc  = m_dp[7:0];
                m_ovf  = m_ovf | m_dp[8];
                m_cnt  = m_cnt + 1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_running = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end else if (m_done) begin
            if (res_ready) m_done = 1'b0;
        end else if (start) begin
            m_running = 1'b1;
            m_left    = (len == 4'd0) ? 16 : int'(len);
            m_float   = float_mode;
            m_acc     = init_acc;
            m_cnt     = 0;
            m_ovf     = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            chk("in_ready",       in_ready,       m_running);
            chk("busy",           busy,           m_running | m_done);
            chk("res_valid",      res_valid,      m_done);
            chk("mul_cumulative", mul_cumulative, m_acc);
            chk("mul_float",      mul_float,      m_float);
            chk("mul_weight",     mul_weight,     in_weight);
            chk("mul_value",      mul_value,      in_value);
            if (m_done) begin
                chk("result",       result,       m_acc);
                chk("res_overflow", res_overflow, m_ovf);
                chk("res_count",    res_count,    m_cnt[4:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [3:0] l, input logic f, input logic [7:0] ia);
        start      = 1'b1;
        len        = l;
        float_mode = f;
        init_acc   = ia;
        step();
        start      = 1'b0;
        len        = 4'd9;
        float_mode = ~f;
        init_acc   = 8'hAA;
    endtask

    task automatic pair(input logic [7:0] w, input logic [7:0] v);
        in_valid  = 1'b1;
        in_weight = w;
        in_value  = v;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic handoff();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},  in_ready,       1'b0);
        chk({tag, "_busy"},      busy,           1'b0);
        chk({tag, "_res_valid"}, res_valid,      1'b0);
        chk({tag, "_result"},    result,         8'h00);
        chk({tag, "_res_ovf"},   res_overflow,   1'b0);
        chk({tag, "_res_count"}, res_count,      5'd0);
        chk({tag, "_mul_cum"},   mul_cumulative, 8'h00);
        chk({tag, "_mul_float"}, mul_float,      1'b0);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; len = 4'd0; float_mode = 1'b0;
        init_acc = 8'h00; abort = 1'b0; in_valid = 1'b0;
        in_weight = 8'h00; in_value = 8'h00; res_ready = 1'b0;
        #1;
        chk_reset_values("rst");
        step();
        n_rst = 1'b1;
        step();

        // int job: 0+6=6, 6-4=2, 2-10=-8
        start_job(4'd3, 1'b0, 8'h00);
        chk("t1_in_ready", in_ready, 1'b1);
        pair(8'd2, 8'd3);
        chk("t1_acc1", mul_cumulative, 8'h06);
        pair(8'd4, 8'hFF);
        chk("t1_acc2", mul_cumulative, 8'h02);
        chk("t1_no_res_yet", res_valid, 1'b0);
        pair(8'hFB, 8'd2);
        chk("t1_res_valid", res_valid, 1'b1);
        chk("t1_result", result, 8'hF8);
        chk("t1_ovf", res_overflow, 1'b0);
        chk("t1_count", res_count, 5'd3);
        handoff();
        chk("t1_idle", busy, 1'b0);

        // saturation is sticky: 100+100 -> 0x7F (ovf), 127-1 = 0x7E
        start_job(4'd2, 1'b0, 8'd100);
        pair(8'd10, 8'd10);
        chk("t2_sat", mul_cumulative, 8'h7F);
        pair(8'hFF, 8'd1);
        chk("t2_result", result, 8'h7E);
        chk("t2_ovf", res_overflow, 1'b1);
        handoff();

        // len 0 means 16 pairs, with a 3-cycle stall midway
        start_job(4'd0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) pair(8'd1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_stall_acc", mul_cumulative, 8'h08);
        end
        for (int i = 0; i < 7; i++) pair(8'd1, 8'd1);
        chk("t3_not_done_15", res_valid, 1'b0);
        pair(8'd1, 8'd1);
        chk("t3_result", result, 8'h10);
        chk("t3_count", res_count, 5'd16);
        handoff();

        // backpressure with start pulses while a result is waiting
        start_job(4'd1, 1'b0, 8'd1);
        pair(8'd3, 8'd3);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 4'd5;
            step();
            start = 1'b0;
            chk("t4_hold_valid", res_valid, 1'b1);
            chk("t4_hold_result", result, 8'h0A);
            chk("t4_hold_count", res_count, 5'd1);
        end
        start = 1'b1;
        handoff();
        start = 1'b0;
        chk("t4_idle_after_handoff", busy, 1'b0);
        step();
        chk("t4_still_idle", busy, 1'b0);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1; len = 4'd2;
        step();
        start = 1'b0; abort = 1'b0;
        chk("t5_abort_vs_start", busy, 1'b0);

        // abort mid-job with a pair offered in the same cycle
        start_job(4'd4, 1'b0, 8'h00);
        pair(8'd1, 8'd1);
        pair(8'd1, 8'd1);
        abort = 1'b1;
        pair(8'd2, 8'd2);
        abort = 1'b0;
        chk("t5_abort_busy", busy, 1'b0);
        chk("t5_abort_acc", mul_cumulative, 8'h00);
        chk("t5_abort_res_valid", res_valid, 1'b0);
        step();
        start_job(4'd1, 1'b0, 8'd5);
        pair(8'd1, 8'd1);
        chk("t5_result", result, 8'h06);
        chk("t5_ovf", res_overflow, 1'b0);
        handoff();

        // float job, then reset mid-run
        start_job(4'd3, 1'b1, 8'h10);
        chk("t6_mul_float", mul_float, 1'b1);
        pair(8'd3, 8'd5);
        chk("t6_acc1", mul_cumulative, 8'h16);
        pair(8'd1, 8'd2);
        chk("t6_acc2", mul_cumulative, 8'h19);
        chk("t6_mul_float_run", mul_float, 1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        chk_reset_values("t6_async_rst");
        step();
        n_rst = 1'b1;
        step();
        chk("t6_post_rst_busy", busy, 1'b0);
        chk("t6_post_rst_float", mul_float, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
